cond_issue_ctrl: RTL and testbench

Condition-issue controller at the ID/EX boundary of the ARM968E-S pipeline. Holds the architectural NZCV status register and tracks outstanding flag-writing instructions, including single-cycle ALU ops and multi-cycle MUL with S. Evaluates each issuing instruction's 4-bit condition field against the flags and stalls issue while a condition would read stale flags. Drives the EX-stage commit enable.

---
 rtl/cond_issue_if.sv | 30 +++
 rtl/cond_issue_ctrl.sv | 119 +++++++++++
 tb/tb_cond_issue_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/cond_issue_if.sv
// Issue/flag-writeback bundle between the ID/EX pipeline and the condition-issue controller.
// The master drives instructions and writebacks; the slave (controller) returns ready, exec and flag state.
interface cond_issue_if #(
    parameter int MAX_PEND = 3
);
    localparam int CNT_W = $clog2(MAX_PEND + 1);

    logic             issue_valid;
    logic             issue_ready;
    logic [3:0]       issue_cond;
    logic             issue_s;
    logic             flush;
    logic             flag_wr;
    logic [3:0]       flag_nzcv;
    logic             exec_valid;
    logic             exec_en;
    logic [3:0]       sr;
    logic [CNT_W-1:0] pend;
    logic             err;

    modport master (
        output issue_valid, issue_cond, issue_s, flush, flag_wr, flag_nzcv,
        input  issue_ready, exec_valid, exec_en, sr, pend, err
    );

    modport slave (
        input  issue_valid, issue_cond, issue_s, flush, flag_wr, flag_nzcv,
        output issue_ready, exec_valid, exec_en, sr, pend, err
    );
endinterface

// File: rtl/cond_issue_ctrl.sv
// Condition-issue controller: holds NZCV, counts outstanding flag writers, stalls stale-flag issue.
// Optional FLAG_FWD_EN forwards the last writer's flags to a waiting conditional instruction.
module cond_issue_ctrl #(
    parameter int MAX_PEND = 3
) (
    input  logic        clk,
    input  logic        rst,
    cond_issue_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_PEND + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FULL
    } state_t;

    // Base predicate from cond[3:1]; cond[0] selects its complement (AL/NV included).
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    logic [3:0]       sr_q, sr_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             exec_valid_q, exec_valid_d;
    logic             exec_en_q, exec_en_d;
    logic             err_q, err_d;

    state_t           state;
    logic             fwd_hit;
    logic [3:0]       flags;
    logic             cond_uncond;
    logic             hazard;
    logic             cap_stall;
    logic             ready;
    logic             accept;
    logic             pass;
    logic             inc;
    logic             dec;

    always_comb begin
        state = ST_BUSY;
        if (pend_q == '0)
            state = ST_IDLE;
        else if (pend_q == CNT_W'(MAX_PEND))
            state = ST_FULL;
    end

    // Issue decision: purely from cond/s/flush/flag_wr and the pending count.
    always_comb begin
`ifdef FLAG_FWD_EN
        fwd_hit = (pend_q == CNT_W'(1)) && bus.flag_wr;
        flags   = fwd_hit ? bus.flag_nzcv : sr_q;
`else
        fwd_hit = 1'b0;
        flags   = sr_q;
`endif
        cond_uncond = (bus.issue_cond[3:1] == 3'b111);
        hazard      = !cond_uncond && (state != ST_IDLE) && !fwd_hit;
        cap_stall   = (state == ST_FULL) && bus.issue_s && !bus.flag_wr;
        ready       = !bus.flush && !hazard && !cap_stall;
        accept      = bus.issue_valid && ready;
        pass        = cond_pass(bus.issue_cond, flags);
        inc         = accept && bus.issue_s && pass;
        dec         = bus.flag_wr && (state != ST_IDLE);
    end

    always_comb begin
        sr_d         = bus.flag_wr ? bus.flag_nzcv : sr_q;
        exec_valid_d = accept;
        exec_en_d    = accept && pass;
        err_d        = err_q || (bus.flag_wr && (state == ST_IDLE));
        pend_d       = pend_q;
        case ({inc, dec})
            2'b10:   pend_d = pend_q + CNT_W'(1);
            2'b01:   pend_d = pend_q - CNT_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    // ID/EX boundary register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q         <= '0;
            pend_q       <= '0;
            exec_valid_q <= 1'b0;
            exec_en_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            pend_q       <= pend_d;
            exec_valid_q <= exec_valid_d;
            exec_en_q    <= exec_en_d;
            err_q        <= err_d;
        end
    end

    assign bus.issue_ready = ready;
    assign bus.exec_valid  = exec_valid_q;
    assign bus.exec_en     = exec_en_q;
    assign bus.sr          = sr_q;
    assign bus.pend        = pend_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Randomized plus directed bench for cond_issue_ctrl against a count/flag-level reference model.
module tb_cond_issue_ctrl;
    localparam int MAX_PEND = 3;

    logic clk = 1'b0;
    logic rst;

    cond_issue_if #(.MAX_PEND(MAX_PEND)) bus ();

    cond_issue_ctrl #(.MAX_PEND(MAX_PEND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int       m_pend;
    logic [3:0] m_sr;
    bit       m_err, m_ev, m_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0; m_sr = 4'h0; m_err = 0; m_ev = 0; m_en = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive, check combinational ready, advance, check registered outputs.
    task automatic cycle(input bit v, input logic [3:0] c, input bit s, input bit fl,
                         input bit fw, input logic [3:0] nz, output bit acc);
        bit fwd, rdy, pass;
        logic [3:0] f;
        bus.issue_valid = v;
        bus.issue_cond  = c;
        bus.issue_s     = s;
        bus.flush       = fl;
        bus.flag_wr     = fw;
        bus.flag_nzcv   = nz;
        #1;
        fwd = 1'b0;
`ifdef FLAG_FWD_EN
        fwd = (m_pend == 1) && fw;
`endif
        rdy = !fl && !((c < 4'd14) && (m_pend != 0) && !fwd) && !((m_pend == MAX_PEND) && s && !fw);
        check("issue_ready", 32'(bus.issue_ready), 32'(rdy));
        acc  = v && rdy;
        f    = fwd ? nz : m_sr;
        pass = ref_pass(c, f);
        @(posedge clk);
        #1;
        m_ev = acc;
        m_en = acc && pass;
        if (fw) begin
            m_sr = nz;
            if (m_pend == 0) m_err = 1'b1;
            else m_pend--;
        end
        if (acc && s && pass) m_pend++;
        check("exec_valid", 32'(bus.exec_valid), 32'(m_ev));
        check("exec_en", 32'(bus.exec_en), 32'(m_en));
        check("sr", 32'(bus.sr), 32'(m_sr));
        check("pend", 32'(bus.pend), 32'(m_pend));
        check("err", 32'(bus.err), 32'(m_err));
    endtask

    bit acc;
    int stalls;
    bit sweep_exp [16] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0};
    bit pending;
    logic [3:0] rc;
    bit rs, rv, rfl, rfw;

    initial begin
        rst = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_cond  = 4'h0;
        bus.issue_s     = 1'b0;
        bus.flush       = 1'b0;
        bus.flag_wr     = 1'b0;
        bus.flag_nzcv   = 4'h0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_exec_valid", 32'(bus.exec_valid), 32'd0);
        check("rst_exec_en", 32'(bus.exec_en), 32'd0);
        check("rst_sr", 32'(bus.sr), 32'd0);
        check("rst_pend", 32'(bus.pend), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_ready", 32'(bus.issue_ready), 32'd1);

        // Stray writeback sets sr and err; EQ then passes on Z
        cycle(0, 4'h0, 0, 0, 1, 4'b0100, acc);
        check("stray_err", 32'(bus.err), 32'd1);
        cycle(1, 4'h0, 0, 0, 0, 4'h0, acc);
        check("eq_acc", 32'(acc), 32'd1);
        check("eq_exec_valid", 32'(bus.exec_valid), 32'd1);
        check("eq_exec_en", 32'(bus.exec_en), 32'd1);
        check("eq_sr", 32'(bus.sr), 32'b0100);

        // ADDS then NE waiting on its flags
        cycle(1, 4'hE, 1, 0, 0, 4'h0, acc);
        stalls = 0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1, 4'h1, 0, 0, (k == 1), 4'b0000, acc);
            if (acc) break;
            stalls++;
        end
        check("ne_accepted", 32'(acc), 32'd1);
`ifdef FLAG_FWD_EN
        check("ne_stalls", 32'(stalls), 32'd1);
`else
        check("ne_stalls", 32'(stalls), 32'd2);
`endif
        check("ne_exec_en", 32'(bus.exec_en), 32'd1);

        // Decode sweep with C=1,V=1
        cycle(1, 4'hE, 1, 0, 0, 4'h0, acc);
        cycle(0, 4'h0, 0, 0, 1, 4'b0011, acc);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 4'(i), 0, 0, 0, 4'h0, acc);
            check($sformatf("sweep_en_%0d", i), 32'(bus.exec_en), 32'(sweep_exp[i]));
        end

        // Capacity: fourth writer stalls in FULL unless a writeback frees a slot
        for (int i = 0; i < 3; i++) cycle(1, 4'hE, 1, 0, 0, 4'h0, acc);
        check("full_pend", 32'(bus.pend), 32'd3);
        cycle(1, 4'hE, 1, 0, 0, 4'h0, acc);
        check("full_stall", 32'(acc), 32'd0);
        cycle(1, 4'hE, 1, 0, 1, 4'b0000, acc);
        check("full_swap_acc", 32'(acc), 32'd1);
        check("full_swap_pend", 32'(bus.pend), 32'd3);

        // Flush cancels the ID instruction
        cycle(1, 4'hE, 0, 1, 0, 4'h0, acc);
        check("flush_exec_valid", 32'(bus.exec_valid), 32'd0);
        cycle(0, 4'h0, 0, 0, 1, 4'b1010, acc);
        check("pre_rst_pend", 32'(bus.pend), 32'd2);
        check("err_sticky", 32'(bus.err), 32'd1);

        // Async reset while NE is stalled behind two writers
        bus.issue_valid = 1'b1;
        bus.issue_cond  = 4'h1;
        bus.issue_s     = 1'b0;
        bus.flag_wr     = 1'b0;
        #1;
        check("stall_ready", 32'(bus.issue_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("async_pend", 32'(bus.pend), 32'd0);
        check("async_sr", 32'(bus.sr), 32'd0);
        check("async_err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        model_reset();
        cycle(1, 4'h1, 0, 0, 0, 4'h0, acc);
        check("post_rst_ne_en", 32'(bus.exec_en), 32'd1);

        // Randomized traffic; stalled instructions hold cond/s
        pending = 0;
        rc = 4'h0;
        rs = 0;
        for (int i = 0; i < 600; i++) begin
            if (!pending) begin
                rc = 4'($urandom_range(0, 15));
                rs = ($urandom_range(0, 1) == 1);
            end
            rv  = pending ? 1'b1 : ($urandom_range(0, 9) < 7);
            rfl = ($urandom_range(0, 9) == 0);
            rfw = (m_pend > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 29) == 0);
            cycle(rv, rc, rs, rfl, rfw, 4'($urandom_range(0, 15)), acc);
            pending = rv && !acc && !rfl;
            if (i == 300) begin
                apply_reset();
                pending = 0;
            end
        end

        apply_reset();
        #1;
        check("final_err", 32'(bus.err), 32'd0);
        check("final_pend", 32'(bus.pend), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
